// File: rtl/gray_seqgen_pkg.sv
// Shared definitions for the Gray sequence generator: step classification
// and the width-generic binary-to-Gray encode.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_INC,
    STEP_DEC
  } step_e;

  // Callers zero-extend to GRAY_MAX_W and truncate back to their own width;
  // the low bits of the result are the Gray code of the narrower value.
  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seqgen_if.sv
// Control/load inputs and registered Gray/binary/wrap outputs of gray_seqgen.
interface gray_seqgen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] bin;
  logic             wrap;

  modport master (
    output en, up, sat, load, load_val,
    input  out, bin, wrap
  );

  modport slave (
    input  en, up, sat, load, load_val,
    output out, bin, wrap
  );
endinterface

// File: rtl/gray_seqgen_gray_to_bin.sv
// Purely combinational reflected-Gray to binary decode.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  // Each binary bit is the running XOR of the Gray bits from the MSB down.
  function automatic logic [WIDTH-1:0] decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign b_o = decode(g_i);

endmodule

// File: rtl/gray_seqgen.sv
// Reflected-Gray sequence generator: binary index register with up/down,
// wrap/saturate, Gray load, and registered Gray, binary and wrap outputs.
module gray_seqgen
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  gray_seqgen_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_IDX = '1;

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;
  step_e            step;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_dec (
    .g_i (bus.load_val),
    .b_o (load_bin)
  );

  always_comb begin
    step = STEP_HOLD;
    if (bus.load) begin
      step = STEP_LOAD;
    end else if (bus.en) begin
      step = bus.up ? STEP_INC : STEP_DEC;
    end
  end

  // Counting happens on the binary index only; Gray is re-encoded from it.
  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    unique case (step)
      STEP_LOAD: b_d = load_bin;
      STEP_INC: begin
        if (b_q != MAX_IDX) begin
          b_d = b_q + WIDTH'(1);
        end else if (!bus.sat) begin
          b_d    = '0;
          wrap_d = 1'b1;
        end
      end
      STEP_DEC: begin
        if (b_q != '0) begin
          b_d = b_q - WIDTH'(1);
        end else if (!bus.sat) begin
          b_d    = MAX_IDX;
          wrap_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gray_d = WIDTH'(bin_to_gray(GRAY_MAX_W'(b_d)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q    <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = gray_q;
  assign bus.bin  = b_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_seqgen.sv
// Scoreboard bench for gray_seqgen: directed WIDTH=4 vectors plus a
// WIDTH=2 / WIDTH=6 full-cycle sweep.
module tb_gray_seqgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sw_rst_n;

  gray_seqgen_if #(.WIDTH(4)) bus4 ();
  gray_seqgen_if #(.WIDTH(2)) bus2 ();
  gray_seqgen_if #(.WIDTH(6)) bus6 ();

  gray_seqgen #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(rst_n),    .bus(bus4));
  gray_seqgen #(.WIDTH(2)) u_dut2 (.clk(clk), .reset(sw_rst_n), .bus(bus2));
  gray_seqgen #(.WIDTH(6)) u_dut6 (.clk(clk), .reset(sw_rst_n), .bus(bus6));

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] bin;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  logic sweep_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] tb_g2b(input logic [31:0] g);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  // Monitor: one expectation per edge that the stimulus issued
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("out",  bus4.out,  e.out);
      chk("bin",  bus4.bin,  e.bin);
      chk("wrap", bus4.wrap, e.wrap);
    end
  end

  task automatic step(input logic en, input logic up, input logic sat, input logic ld,
                      input logic [3:0] lv, input logic [3:0] eo, input logic [3:0] eb,
                      input logic ew);
    @(negedge clk);
    bus4.en = en; bus4.up = up; bus4.sat = sat; bus4.load = ld; bus4.load_val = lv;
    sb_q.push_back('{out: eo, bin: eb, wrap: ew});
  endtask

  // Pulse reset between edges, check the async clear, then release with new controls.
  task automatic reset_then(input logic en, input logic up, input logic sat,
                            input logic [3:0] eo, input logic [3:0] eb, input logic ew);
    @(negedge clk);
    rst_n = 1'b0;
    bus4.en = en; bus4.up = up; bus4.sat = sat; bus4.load = 1'b0; bus4.load_val = '0;
    #1;
    chk("rst_out",  bus4.out,  0);
    chk("rst_bin",  bus4.bin,  0);
    chk("rst_wrap", bus4.wrap, 0);
    #1;
    rst_n = 1'b1;
    sb_q.push_back('{out: eo, bin: eb, wrap: ew});
  endtask

  logic [3:0] cnt_tab [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                               4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                               4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin : main
    rst_n = 1'b1;
    bus4.en = 1'b0; bus4.up = 1'b1; bus4.sat = 1'b0; bus4.load = 1'b0; bus4.load_val = '0;

    // Forward count through the full legacy sequence
    reset_then(1'b1, 1'b1, 1'b0, cnt_tab[0], 4'd1, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, cnt_tab[k], 4'(k + 1), (k == 15));
    end

    // Down from reset wraps to the top
    reset_then(1'b1, 1'b0, 1'b0, 4'b1000, 4'd15, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0);

    // Saturate at the top, then step back down
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'd15, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0);

    // Load beats en at the boundary; then back-to-back wraps
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'd15, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000, 4'd15, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0,  1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0,  1'b1);

    // Load priority from 0101
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0101, 4'd6,  1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1110, 4'b1110, 4'd11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'd12, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'd12, 1'b0);

    // Async reset mid-run at 1101 with en/load active
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b1101, 4'b1101, 4'd9,  1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1101, 4'd9,  1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus4.en = 1'b1; bus4.load = 1'b1; bus4.load_val = 4'b0110;
    #1;
    chk("async_out",  bus4.out,  0);
    chk("async_bin",  bus4.bin,  0);
    chk("async_wrap", bus4.wrap, 0);
    @(posedge clk);
    #2;
    chk("held_out",  bus4.out,  0);
    chk("held_bin",  bus4.bin,  0);
    chk("held_wrap", bus4.wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.load = 1'b0; bus4.up = 1'b1;
    sb_q.push_back('{out: 4'b0001, bin: 4'd1, wrap: 1'b0});

    for (int k = 0; k < 400 && !sweep_done; k++) @(posedge clk);
    chk("sweep_finished", sweep_done, 1);
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : sweep
    logic [1:0] b2, pg2;
    logic [5:0] b6, pg6;
    int w2, w6;
    w2 = 0; w6 = 0; b2 = '0; b6 = '0; pg2 = '0; pg6 = '0;
    sw_rst_n = 1'b1;
    bus2.en = 1'b0; bus2.up = 1'b1; bus2.sat = 1'b0; bus2.load = 1'b0; bus2.load_val = '0;
    bus6.en = 1'b0; bus6.up = 1'b1; bus6.sat = 1'b0; bus6.load = 1'b0; bus6.load_val = '0;
    #1 sw_rst_n = 1'b0;
    @(negedge clk);
    sw_rst_n = 1'b1;
    bus2.en = 1'b1;
    bus6.en = 1'b1;
    for (int k = 0; k < 128; k++) begin
      @(posedge clk);
      #2;
      b2 = b2 + 2'd1;
      b6 = b6 + 6'd1;
      chk("w2_out",  bus2.out,  b2 ^ (b2 >> 1));
      chk("w2_bin",  bus2.bin,  b2);
      chk("w2_wrap", bus2.wrap, (b2 == 2'd0));
      chk("w2_onebit", $countones(bus2.out ^ pg2), 1);
      chk("w2_bin_vs_out", bus2.bin, tb_g2b(32'(bus2.out)));
      chk("w6_out",  bus6.out,  b6 ^ (b6 >> 1));
      chk("w6_bin",  bus6.bin,  b6);
      chk("w6_wrap", bus6.wrap, (b6 == 6'd0));
      chk("w6_onebit", $countones(bus6.out ^ pg6), 1);
      chk("w6_bin_vs_out", bus6.bin, tb_g2b(32'(bus6.out)));
      if (bus2.wrap) w2++;
      if (bus6.wrap) w6++;
      pg2 = bus2.out;
      pg6 = bus6.out;
    end
    chk("w2_wrap_count", w2, 32);
    chk("w6_wrap_count", w6, 2);
    sweep_done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

endmodule
